// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
// Optional store-to-load forwarding is enabled with STORE_BUFFER_FORWARD_EN.
package store_buffer_pkg;

  // Access width encodings shared by CPU and memory sides
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_NONE = 2'b11;

  // One buffered store
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } sb_entry_t;

  // Access size in bytes; W_NONE moves no bytes
  function automatic logic [2:0] size_from_width(input logic [1:0] w);
    logic [2:0] s;
    case (w)
      W_BYTE:  s = 3'd1;
      W_HALF:  s = 3'd2;
      W_WORD:  s = 3'd4;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  // Truncate buffered store data to the load width and extend it
  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] w,
                                              input logic sx);
    logic [31:0] r;
    case (w)
      W_BYTE:  r = sx ? {{24{d[7]}}, d[7:0]} : {24'd0, d[7:0]};
      W_HALF:  r = sx ? {{16{d[15]}}, d[15:0]} : {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_overlap.sv
// sb_overlap: word-span overlap test between a load and one buffered store.
// With STORE_BUFFER_FORWARD_EN it is also one stage of an oldest-to-youngest
// priority chain, so the last stage carries the youngest overlapping entry.
module sb_overlap
  import store_buffer_pkg::*;
(
  input  logic        ent_valid_i,
  input  logic [31:0] ent_addr_i,
  input  logic [1:0]  ent_width_i,
  input  logic [31:0] ld_addr_i,
  input  logic [1:0]  ld_width_i,
`ifdef STORE_BUFFER_FORWARD_EN
  input  logic [31:0] ent_data_i,
  input  logic        prio_hit_i,
  input  logic        prio_exact_i,
  input  logic [31:0] prio_data_i,
  output logic        prio_hit_o,
  output logic        prio_exact_o,
  output logic [31:0] prio_data_o,
`endif
  output logic        hit_o
);

  logic [29:0] ent_first;
  logic [29:0] ent_last;
  logic [29:0] ld_first;
  logic [29:0] ld_last;

  // Word index of the last byte touched; a zero-size access is treated as one byte
  function automatic logic [29:0] last_word(input logic [31:0] a, input logic [1:0] w);
    logic [2:0]  s;
    logic [31:0] e;
    s = size_from_width(w);
    e = a + {29'd0, (s == 3'd0) ? 3'd0 : (s - 3'd1)};
    return e[31:2];
  endfunction

  // Spans are at most two adjacent words, so four endpoint compares cover every overlap
  always_comb begin
    ent_first = ent_addr_i[31:2];
    ent_last  = last_word(ent_addr_i, ent_width_i);
    ld_first  = ld_addr_i[31:2];
    ld_last   = last_word(ld_addr_i, ld_width_i);
    hit_o     = ent_valid_i &
                ((ent_first == ld_first) | (ent_first == ld_last) |
                 (ent_last  == ld_first) | (ent_last  == ld_last));
  end

`ifdef STORE_BUFFER_FORWARD_EN
  logic exact;

  // A younger hit overrides whatever older stages selected
  always_comb begin
    exact        = (ent_addr_i == ld_addr_i) & (ent_width_i == ld_width_i) &
                   (ent_width_i != W_NONE);
    prio_hit_o   = hit_o | prio_hit_i;
    prio_exact_o = hit_o ? exact : prio_exact_i;
    prio_data_o  = hit_o ? ent_data_i : prio_data_i;
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: queues CPU stores and drains them to a single-port memory in
// cycles the port is not used by a load. Loads overlapping a queued store stall.
// Define STORE_BUFFER_FORWARD_EN to forward exact-match store data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_width,
  input  logic        req_sign_extend,
  output logic        req_ready,
  output logic [31:0] rsp_data,
  input  logic        fence,
  output logic        empty,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [1:0]  mem_width,
  output logic        mem_write,
  output logic        mem_sign_extend,
  input  logic [31:0] mem_result
);

  sb_entry_t        fifo_q [DEPTH];
  sb_entry_t        head_ent;
  logic [PTR_W:0]   head_q, head_d;
  logic [PTR_W:0]   tail_q, tail_d;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty_w;
  logic [DEPTH-1:0] hit_vec;
  logic             hazard;
  logic             fwd_ok;
  logic             is_load, is_store;
  logic             load_port, load_fwd;
  logic             drain, push;

  assign count    = tail_q - head_q;
  assign empty_w  = (head_q == tail_q);
  assign full     = (head_q[PTR_W] != tail_q[PTR_W]) &&
                    (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  assign empty    = empty_w;
  assign head_ent = fifo_q[head_q[PTR_W-1:0]];
  assign hazard   = |hit_vec;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [DEPTH:0] prio_hit;
  logic [DEPTH:0] prio_exact;
  logic [31:0]    prio_data [DEPTH+1];
  logic [31:0]    fwd_data;

  assign prio_hit[0]   = 1'b0;
  assign prio_exact[0] = 1'b0;
  assign prio_data[0]  = 32'd0;
  assign fwd_ok        = prio_hit[DEPTH] & prio_exact[DEPTH];
  assign fwd_data      = extend_load(prio_data[DEPTH], req_width, req_sign_extend);
`else
  assign fwd_ok = 1'b0;
`endif

  // Overlap checkers indexed by age: gi = 0 is the head (oldest) entry
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PTR_W-1:0] slot;
    logic             valid;
    assign slot  = head_q[PTR_W-1:0] + PTR_W'(gi);
    assign valid = ((PTR_W+1)'(gi) < count);

    sb_overlap u_ovl (
      .ent_valid_i  (valid),
      .ent_addr_i   (fifo_q[slot].addr),
      .ent_width_i  (fifo_q[slot].width),
      .ld_addr_i    (req_addr),
      .ld_width_i   (req_width),
`ifdef STORE_BUFFER_FORWARD_EN
      .ent_data_i   (fifo_q[slot].data),
      .prio_hit_i   (prio_hit[gi]),
      .prio_exact_i (prio_exact[gi]),
      .prio_data_i  (prio_data[gi]),
      .prio_hit_o   (prio_hit[gi+1]),
      .prio_exact_o (prio_exact[gi+1]),
      .prio_data_o  (prio_data[gi+1]),
`endif
      .hit_o        (hit_vec[gi])
    );
  end

  // Arbitrate the single memory port between a bypassing load and the head drain
  always_comb begin
    is_load   = req_valid & ~req_write & ~fence;
    is_store  = req_valid &  req_write & ~fence;
    load_port = is_load & ~hazard;
    load_fwd  = is_load & hazard & fwd_ok;
    drain     = ~empty_w & ~load_port;
    push      = is_store & (req_width != W_NONE) & (~full | drain);
    req_ready = load_port | load_fwd |
                (is_store & ((req_width == W_NONE) | ~full | drain));
    head_d    = head_q + {{PTR_W{1'b0}}, drain};
    tail_d    = tail_q + {{PTR_W{1'b0}}, push};
  end

  // Drive the memory port and the load response
  always_comb begin
    mem_addr        = 32'd0;
    mem_data        = 32'd0;
    mem_width       = 2'b00;
    mem_write       = 1'b0;
    mem_sign_extend = 1'b0;
    rsp_data        = 32'd0;
    if (load_port) begin
      mem_addr        = req_addr;
      mem_width       = req_width;
      mem_sign_extend = req_sign_extend;
      rsp_data        = mem_result;
    end else if (drain) begin
      mem_addr  = head_ent.addr;
      mem_data  = head_ent.data;
      mem_width = head_ent.width;
      mem_write = 1'b1;
    end
`ifdef STORE_BUFFER_FORWARD_EN
    if (load_fwd) begin
      rsp_data = fwd_data;
    end
`endif
  end

  // Pointer registers; reset discards every pending store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[tail_q[PTR_W-1:0]] <= '{addr: req_addr, data: req_data, width: req_width};
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM-stage load/store request and the single-port data memory.
- Queues stores in a small FIFO and drains them to memory in idle memory-port cycles, so loads do not wait behind stores.
- Loads bypass the queue and go to the memory port directly unless they overlap a pending store; in that case the load stalls.
- Also supports a fence (wait-until-empty) for pipeline flush points.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU access request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; may be unaligned
- req_data  in  32  store data, low bytes used per width
- req_width  in  2  00 = byte, 01 = half, 10 = word, 11 = none
- req_sign_extend  in  1  load sign extension
- req_ready  out  1  request accepted this cycle; CPU holds the request while 0
- rsp_data  out  32  load result; valid in the same cycle as req_ready for loads
- fence  in  1  request drain-to-empty
- empty  out  1  FIFO has no entries
- mem_addr  out  32  to memory address
- mem_data  out  32  to memory write data
- mem_width  out  2  to memory access width
- mem_write  out  1  to memory write enable
- mem_sign_extend  out  1  to memory sign extension
- mem_result  in  32  combinational read data from memory

Behaviour:
- FIFO entry fields: {addr[31:0], data[31:0], width[1:0]}. Head/tail pointers are PTR_W+1 bits; full/empty are derived from the pointer MSB compare.
- Reset (async): pointers = 0, empty = 1, FIFO contents are don't-care. Pending stores are discarded, including on reset mid-drain.
- Word span of an access at A with size S (1/2/4): {A[31:2], (A+S−1)[31:2]}, wrapping mod 2^30.
- Hazard: a load's span shares any word with the span of any valid entry.
- Arbitration, evaluated combinationally each cycle; the memory port carries at most one operation:
  1. Load, no hazard: mem port = load (mem_write = 0); req_ready = 1; rsp_data = mem_result; no drain this cycle.
  2. Load, hazard: req_ready = 0; head drains.
  3. Store, width 11: req_ready = 1; nothing enqueued; the drain proceeds.
  4. Store, width ≠ 11: req_ready = 1 when not full, or when full and the head drains this cycle (simultaneous pop and push). The enqueue is registered at the edge.
  5. No request: head drains if not empty.
- Drain: mem port = head entry with mem_write = 1; the pop occurs at the same rising edge as the memory write.
- Idle port: mem_write = 0, other mem outputs = 0.
- Store latency: a store accepted at edge N is written to memory no earlier than edge N+1. It is visible to loads through the hazard stall only, never stale.
- Ordering: stores drain strictly in FIFO order.
- fence = 1: req_ready forced to 0 for all requests; draining continues. The CPU deasserts fence once empty = 1. A fence asserted with the FIFO empty costs zero extra cycles beyond the forced stall.
- rsp_data is 0 when no load is accepted.
- Simultaneous push to an empty FIFO and no drain: the entry is valid next cycle and drains then.

Optional Feature:
- Macro: STORE_BUFFER_FORWARD_EN.
- Defined: if the youngest overlapping entry has an address and width exactly equal to the load's, and its width ≠ 11:
  - rsp_data = that entry's data, truncated and sign/zero-extended per req_width and req_sign_extend;
  - req_ready = 1, and the port stays free for a drain that cycle.
  - Any other overlap stalls as usual.
- Undefined: every overlap stalls; no forwarding logic is instantiated.

Decomposition:
- Shared package holds:
  - width encodings (W_BYTE = 2'b00, W_HALF = 2'b01, W_WORD = 2'b10, W_NONE = 2'b11);
  - the sb_entry_t struct;
  - a function for size-from-width.
- One sub-module, sb_overlap, handles span computation and the per-entry compare. It is instantiated per entry and reduced with OR; in the forward build it also performs the youngest-match priority select.

Test Plan:
- Reset mid-drain: 3 stores queued, assert rst → empty = 1 immediately, mem_write = 0, and no further writes.
- Store word 0xDEADBEEF @0x100, then 3 idle cycles → exactly one mem write of 0x100/0xDEADBEEF/10 at the next edge; empty = 1 afterwards.
- Fill DEPTH stores, then keep presenting stores → 5th store has req_ready = 1 only in a drain cycle, and memory sees the stores in order.
- Pending half store @0x203, load byte @0x204 (shared word 0x81) → req_ready = 0 until the entry drains; then the load returns the stored byte (0x12 from data 0x1234).
- Load @0x400 with store @0x100 pending → req_ready = 1 same cycle with mem_result; drain deferred one cycle.
- Forward build, byte store 0x80 @0x10, signed byte load @0x10 → same-cycle rsp_data = 0xFFFFFF80, with a drain in that cycle. Non-forward build → stall.
